// File: rtl/dt_pkg.sv
// dt_pkg: shared state encoding and geometry constants for the DT result arbiter
package dt_pkg;
    localparam int IMG_W      = 128;
    localparam int RAM_DEPTH  = IMG_W * IMG_W;
    localparam int ADDR_W_DEF = 14;
    localparam int DATA_W_DEF = 8;
    localparam int CNT_W_DEF  = 16;
    typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_e;
endpackage

// File: rtl/dt_res_arbiter.sv
// dt_res_arbiter: owns the result RAM, shares it between the DT engine and a host port, and sequences engine runs
module dt_res_arbiter
    import dt_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              clr,
    output logic              busy,
    output logic              done,
    output logic              dt_rst_n,
    input  logic              dt_done,
    input  logic [ADDR_W-1:0] dt_res_addr,
    input  logic              dt_res_wr,
    input  logic              dt_res_rd,
    input  logic [DATA_W-1:0] dt_res_do,
    output logic [DATA_W-1:0] dt_res_di,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_err,
    output logic [CNT_W-1:0]  host_wait,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr,
    output logic              mem_rd,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic              dt_rst_n_q, dt_rst_n_d;
    logic              host_rvalid_q, host_rvalid_d;
    logic [DATA_W-1:0] host_rdata_q, host_rdata_d;
    logic              host_err_q, host_err_d;
    logic [CNT_W-1:0]  host_wait_q, host_wait_d;
    logic              eng_act;
    logic              start_ok;

    // next state, host grant and RAM port mux; the engine always wins in RUN since it cannot stall
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        eng_act   = dt_res_wr | dt_res_rd;
        start_ok  = (state_q == IDLE || state_q == DONE) & start & ~clr;
        host_gnt  = 1'b0;
        mem_addr  = '0;
        mem_wr    = 1'b0;
        mem_rd    = 1'b0;
        mem_wdata = '0;
        case (state_q)
            IDLE, DONE: begin
                state_d  = clr ? CLEAR : start ? RUN : state_q;
                host_gnt = host_req;
            end
            CLEAR: begin
                clr_cnt_d = clr_cnt_q + 1'b1;
                state_d   = &clr_cnt_q ? IDLE : CLEAR;
                mem_addr  = clr_cnt_q;
                mem_wr    = 1'b1;
            end
            RUN: begin
                state_d  = dt_done ? DONE : RUN;
                host_gnt = host_req & ~host_we & ~eng_act;
                if (eng_act) begin
                    mem_addr  = dt_res_addr;
                    mem_wr    = dt_res_wr;
                    mem_rd    = dt_res_rd;
                    mem_wdata = dt_res_do;
                end
            end
            default: state_d = IDLE;
        endcase
        if (host_gnt) begin
            mem_addr  = host_addr;
            mem_wr    = host_we;
            mem_rd    = ~host_we;
            mem_wdata = host_wdata;
        end
        dt_rst_n_d    = state_d == RUN;
        host_rvalid_d = host_gnt & ~host_we;
        host_rdata_d  = host_rvalid_d ? mem_rdata : host_rdata_q;
        host_err_d    = (state_q == RUN) & host_req & host_we;
        host_wait_d   = start_ok ? '0
                      : (host_req & ~host_gnt & ~&host_wait_q) ? host_wait_q + 1'b1
                      : host_wait_q;
    end

    // state and host-side registers; reset parks the engine immediately
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            clr_cnt_q     <= '0;
            dt_rst_n_q    <= 1'b0;
            host_rvalid_q <= 1'b0;
            host_rdata_q  <= '0;
            host_err_q    <= 1'b0;
            host_wait_q   <= '0;
        end else begin
            state_q       <= state_d;
            clr_cnt_q     <= clr_cnt_d;
            dt_rst_n_q    <= dt_rst_n_d;
            host_rvalid_q <= host_rvalid_d;
            host_rdata_q  <= host_rdata_d;
            host_err_q    <= host_err_d;
            host_wait_q   <= host_wait_d;
        end
    end

    assign busy        = state_q == CLEAR || state_q == RUN;
    assign done        = state_q == DONE;
    assign dt_rst_n    = dt_rst_n_q;
    assign dt_res_di   = mem_rdata;
    assign host_rvalid = host_rvalid_q;
    assign host_rdata  = host_rdata_q;
    assign host_err    = host_err_q;
    assign host_wait   = host_wait_q;
endmodule

// File: doc/dt_res_arbiter.md
Name: dt_res_arbiter

Overview:
- Owns the single-port 16384x8 result RAM (128x128 image, 14-bit address) and shares it between the distance-transform engine and a host access port.
- Sequences the engine: holds it in reset, releases it on start, catches its one-cycle done pulse and parks it again.
- Provides a zero-fill sweep of the RAM before a run.
- Sits between the engine's res_* port, the RAM macro and the host/testbench bus.

Parameters:
- ADDR_W, 14, RAM address width (RAM depth = 2^ADDR_W).
- DATA_W, 8, RAM data width.
- CNT_W, 16, width of the host wait-cycle counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse: launch an engine run.
- clr  in  1  one-cycle pulse: zero-fill the whole RAM.
- busy  out  1  high in CLEAR or RUN.
- done  out  1  level; high in DONE until the next start or clr.
- dt_rst_n  out  1  registered active-low reset to the engine.
- dt_done  in  1  engine done pulse.
- dt_res_addr  in  ADDR_W  engine RAM address.
- dt_res_wr  in  1  engine write strobe.
- dt_res_rd  in  1  engine read strobe.
- dt_res_do  in  DATA_W  engine write data.
- dt_res_di  out  DATA_W  read data to engine; equals mem_rdata at all times.
- host_req  in  1  host access request.
- host_we  in  1  1 = write, 0 = read.
- host_addr  in  ADDR_W  host address.
- host_wdata  in  DATA_W  host write data.
- host_gnt  out  1  combinational; the access is performed in this cycle.
- host_rvalid  out  1  registered; host_rdata is valid.
- host_rdata  out  DATA_W  registered read data.
- host_err  out  1  registered one-cycle pulse: host write refused during RUN.
- host_wait  out  CNT_W  saturating count of host_req & !host_gnt cycles.
- mem_addr  out  ADDR_W  RAM address.
- mem_wr  out  1  RAM write enable.
- mem_rd  out  1  RAM read enable.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data, combinational (same cycle).

Behaviour:
- Reset values:
  - state = IDLE; dt_rst_n = 0.
  - host_rvalid, host_rdata, host_err, host_wait all 0; clear address counter 0.
  - Outputs derived from state (busy, done, mem_* muxes) follow IDLE.
- State machine:
  - IDLE:
    - clr -> CLEAR.
    - else start -> RUN.
    - clr has priority over start when both are asserted.
  - CLEAR:
    - Each cycle: mem_wr = 1, mem_wdata = 0, mem_addr = clear counter.
    - Counter increments every cycle.
    - When the counter equals 2^ADDR_W-1 (write performed) -> IDLE; counter wraps to 0.
    - Exactly 16384 cycles for the default parameters.
    - start/clr are ignored.
  - RUN:
    - dt_rst_n goes to 1 on the clock edge that enters RUN.
    - mem_* follow the dt_res_* inputs.
    - dt_done = 1 -> DONE; dt_rst_n drops to 0 on the same edge, so the engine cannot restart.
    - start/clr are ignored.
  - DONE:
    - done = 1.
    - start -> RUN; clr -> CLEAR; clr has priority.
  - Unused encodings -> IDLE.
- Engine priority:
  - The engine has no stall input, so in RUN it always owns the RAM on any cycle with dt_res_wr | dt_res_rd.
- Host grant (combinational):
  - IDLE / DONE: host_gnt = host_req.
  - CLEAR: host_gnt = 0.
  - RUN: host_gnt = host_req & !host_we & !(dt_res_wr | dt_res_rd). Idle engine cycles are stolen for reads only.
  - On grant, mem_addr = host_addr. Write: mem_wr = 1, mem_wdata = host_wdata. Read: mem_rd = 1.
- Host read return:
  - A granted read registers host_rdata <= mem_rdata, with host_rvalid = 1 in the next cycle.
  - Otherwise host_rvalid = 0 and host_rdata holds its value.
- Host error:
  - Host write requested in RUN: not granted; host_err = 1 in the next cycle, for every such cycle.
  - The host must keep host_req asserted until host_gnt.
- host_wait:
  - Increments on each host_req & !host_gnt cycle.
  - Saturates at 2^CNT_W-1.
  - Clears to 0 on an accepted start.
- Idle RAM port: when neither side is selected, mem_wr = mem_rd = 0, mem_addr = 0, mem_wdata = 0.
- Reset mid-CLEAR or mid-RUN: immediate IDLE and dt_rst_n = 0. RAM contents are undefined; no recovery is attempted.
- dt_done outside RUN is ignored.

Decomposition:
- Package dt_pkg:
  - state enum {IDLE, CLEAR, RUN, DONE}.
  - Constants IMG_W = 128 and RAM_DEPTH = 16384.
  - DATA_W/ADDR_W defaults.
- No sub-module; the FSM, grant mux and counters form one block.
- Optional: a small dt_sat_counter for host_wait.

Test Plan:
- Zero-fill: RAM preloaded with 0xFF; pulse clr in IDLE -> busy high for exactly 16384 cycles; mem_wr every cycle over addresses 0..16383 with data 0; then IDLE, and a host read of address 0x1234 returns 0x00 with host_rvalid one cycle after grant.
- Run sequencing: start in IDLE -> dt_rst_n = 1 on the next edge; engine model pulses dt_done at cycle N -> dt_rst_n = 0 and done = 1 at N+1; done stays high for 10 idle cycles.
- Stolen read: in RUN, host reads address 5 (preloaded 0x2A) while the engine strobes on cycles 0-2 and idles on cycle 3 -> host_gnt only at cycle 3; host_rdata = 0x2A, host_rvalid at cycle 4; host_wait = 3.
- Refused write: host_we = 1 held for 4 cycles in RUN -> host_gnt stays 0; host_err high for 4 cycles; RAM location unchanged.
- Priority / ignore: clr and start pulsed together in DONE -> CLEAR entered; start pulsed during CLEAR -> ignored and IDLE follows.
- Async reset: reset asserted mid-RUN -> state IDLE and dt_rst_n = 0 immediately, without waiting for clk; host_wait = 0 and host_rvalid = 0.
